neuron_array_core: RTL

Time-multiplexed array of fixed-point two-variable (v, w) neuron models sharing one 4-stage arithmetic pipeline. Per-neuron state lives in internal register banks. Each accepted input current advances the next neuron in round-robin order by one Euler step. The block sits between the stimulus/current-injection front end and the spike/state readout logic, replacing per-neuron single-core instances.

---
 rtl/neuron_array_if.sv | 27 ++
 rtl/neuron_array_core.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/neuron_array_if.sv
// Handshake bundle between the current-injection front end, the neuron array
// core and the spike/state readout.
interface neuron_array_if #(
    parameter int W    = 16,
    parameter int IDXW = 4
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_current;
    logic [IDXW-1:0]     in_idx;
    logic                clear;
    logic                out_valid;
    logic                out_ready;
    logic [IDXW-1:0]     out_idx;
    logic signed [W-1:0] v_out;
    logic signed [W-1:0] w_out;
    logic                spike;

    modport master (
        output in_valid, in_current, clear, out_ready,
        input  in_ready, in_idx, out_valid, out_idx, v_out, w_out, spike
    );
    modport slave (
        input  in_valid, in_current, clear, out_ready,
        output in_ready, in_idx, out_valid, out_idx, v_out, w_out, spike
    );
endinterface

// File: rtl/neuron_array_core.sv
// Round-robin array of fixed-point (v, w) neurons sharing one 4-stage Euler
// pipeline; per-neuron state is held in flop banks written back from stage 4.
module neuron_array_core #(
    parameter int INT_WIDTH    = 3,
    parameter int FRC_WIDTH    = 12,
    parameter int N_NEURONS    = 16,
    parameter int TIME_SHIFT   = 7,
    parameter int TAU_SHIFT    = 1,
    parameter int A_CONST      = 2867,
    parameter int DEAD_BAND    = 175,
    parameter int SPIKE_THRESH = 4096,
    parameter int V_RESET      = -4895,
    parameter int W_RESET      = -2560
) (
    input logic          clk,
    input logic          rst,
    neuron_array_if.slave bus
);
    localparam int W      = 1 + INT_WIDTH + FRC_WIDTH;
    localparam int XW     = W + 4;
    localparam int IDXW   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int TS     = TAU_SHIFT + TIME_SHIFT;
    localparam int BW     = FRC_WIDTH + (1 << INT_WIDTH) + 1;
    localparam int STAGES = 4;

    localparam logic signed [W-1:0]   VRST = W'(V_RESET);
    localparam logic signed [W-1:0]   WRST = W'(W_RESET);
    localparam logic signed [W-1:0]   THR  = W'(SPIKE_THRESH);
    localparam logic signed [W-1:0]   WMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [XW-1:0]  SMAX = XW'(WMAX);
    localparam logic signed [XW-1:0]  SMIN = ~SMAX;
    localparam logic signed [XW-1:0]  DB   = XW'(DEAD_BAND);
    localparam logic signed [XW-1:0]  RNDT = XW'(1 << (TIME_SHIFT - 1));
    localparam logic signed [W+1:0]   RNDS = (W+2)'(1 << (TS - 1));
    localparam logic signed [W+1:0]   ACON = (W+2)'(A_CONST);

    typedef struct packed {
        logic [IDXW-1:0]     idx;
        logic signed [W-1:0] v, w, i, pa, pb;
        logic signed [W+1:0] y1;
    } s1_t;
    typedef struct packed {
        logic [IDXW-1:0]      idx;
        logic signed [W-1:0]  v, w, i;
        logic signed [XW-1:0] p, q;
        logic signed [W+1:0]  yw;
    } s2_t;
    typedef struct packed {
        logic [IDXW-1:0]      idx;
        logic signed [W-1:0]  v, wn;
        logic signed [XW-1:0] dv;
    } s3_t;

    function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] x);
        if (x > SMAX)      sat = WMAX;
        else if (x < SMIN) sat = ~WMAX;
        else               sat = x[W-1:0];
    endfunction

    // 2^x with the fractional part linearised: (1 + frac) shifted by floor(x).
    function automatic logic signed [W-1:0] pow2(input logic signed [W-1:0] x);
        logic [INT_WIDTH:0] ip, nsh;
        logic [BW-1:0]      big;
        ip  = x[W-1:FRC_WIDTH];
        nsh = -ip;
        big = {{(1 << INT_WIDTH){1'b0}}, 1'b1, x[FRC_WIDTH-1:0]};
        if (ip[INT_WIDTH]) big = big >> nsh;
        else               big = big << ip[INT_WIDTH-1:0];
        pow2 = (|big[BW-1:W-1]) ? WMAX : {1'b0, big[W-2:0]};
    endfunction

    // Negating the most negative value would wrap; clamp it instead.
    function automatic logic signed [W-1:0] neg(input logic signed [W-1:0] x);
        neg = (x == ~WMAX) ? WMAX : -x;
    endfunction

    logic signed [W-1:0]  v_bank [N_NEURONS];
    logic signed [W-1:0]  w_bank [N_NEURONS];
    logic [STAGES:1]      vld_pipe;
    logic [IDXW-1:0]      idx, out_idx;
    logic signed [W-1:0]  vr, wr, v_o, w_o, vn;
    logic                 spk, spk_o, clr_pend, adv, acc;
    logic signed [XW-1:0] d, dv;
    s1_t s1, s1_n;
    s2_t s2, s2_n;
    s3_t s3, s3_n;

    assign adv = !(vld_pipe[STAGES] && !bus.out_ready);
    assign bus.in_ready = adv && !bus.clear && !clr_pend;
    assign acc = bus.in_valid && bus.in_ready;
    assign vr  = v_bank[idx];
    assign wr  = w_bank[idx];

    assign bus.in_idx    = idx;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out_idx   = out_idx;
    assign bus.v_out     = v_o;
    assign bus.w_out     = w_o;
    assign bus.spike     = spk_o;

    always_comb begin
        s1_n.idx = idx;
        s1_n.v   = vr;
        s1_n.w   = wr;
        s1_n.i   = bus.in_current;
        s1_n.pa  = pow2(vr);
        s1_n.pb  = pow2(neg(vr));
        s1_n.y1  = (W+2)'(vr) + ACON - (W+2)'(wr >>> 1);

        d        = XW'(s1.pb) - XW'(s1.pa);
        s2_n.idx = s1.idx;
        s2_n.v   = s1.v;
        s2_n.w   = s1.w;
        s2_n.i   = s1.i;
        s2_n.p   = d + (d <<< 1);
        s2_n.q   = XW'(s1.v) + (XW'(s1.v) <<< 2);
        s2_n.yw  = (s1.y1 + RNDS) >>> TS;

        dv = s2.p + s2.q - XW'(s2.w) + XW'(s2.i);
        if ((dv > -DB) && (dv < DB)) dv = '0;
        s3_n.idx = s2.idx;
        s3_n.v   = s2.v;
        s3_n.dv  = dv;
        s3_n.wn  = sat(XW'(s2.w) + XW'(s2.yw));

        vn  = sat(XW'(s3.v) + ((s3.dv + RNDT) >>> TIME_SHIFT));
        spk = (s3.v < THR) && (vn >= THR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                v_bank[k] <= VRST;
                w_bank[k] <= WRST;
            end
            vld_pipe <= '0;
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            idx      <= '0;
            out_idx  <= '0;
            v_o      <= VRST;
            w_o      <= WRST;
            spk_o    <= 1'b0;
            clr_pend <= 1'b0;
        end else begin
            if (adv) begin
                vld_pipe <= {vld_pipe[STAGES-1:1], acc};
                s1 <= s1_n;
                s2 <= s2_n;
                s3 <= s3_n;
                if (acc) idx <= (idx == IDXW'(N_NEURONS - 1)) ? '0 : idx + 1'b1;
                if (vld_pipe[STAGES-1]) begin
                    v_bank[s3.idx] <= vn;
                    w_bank[s3.idx] <= s3.wn;
                    out_idx        <= s3.idx;
                    v_o            <= vn;
                    w_o            <= s3.wn;
                    spk_o          <= spk;
                end
            end
            // Reload only once every in-flight writeback has landed.
            if (bus.clear) begin
                clr_pend <= 1'b1;
            end else if (clr_pend && !(|vld_pipe[STAGES-1:1])) begin
                clr_pend <= 1'b0;
                idx      <= '0;
                for (int k = 0; k < N_NEURONS; k++) begin
                    v_bank[k] <= VRST;
                    w_bank[k] <= WRST;
                end
            end
        end
    end
endmodule
